// File: rtl/instr_fetch_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | instr_fetch_issue : PC owner, req/ack instruction fetch, field issue     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module instr_fetch_issue #(
  parameter int unsigned   AW       = 16,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_ack,
  input  logic [15:0]   imem_rdata,
  output logic          issue_valid,
  input  logic          issue_ready,
  output logic [3:0]    opcode,
  output logic [3:0]    func,
  output logic [3:0]    rs,
  output logic [3:0]    rt,
  output logic [3:0]    imm,
  output logic [AW-1:0] issue_pc,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic          halted
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [3:0] OP_JMP  = 4'b0110;
  localparam logic [3:0] OP_HALT = 4'b1111;

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [15:0]   ir_q, ir_d;
  logic          discard_q, discard_d;
  logic [AW-1:0] jmp_pc;
  logic [15:0]   ir_vis;
  logic          accept;

  // jmp replaces the low 12 bits of the PC and keeps the upper page
  generate
    if (AW > 12) begin : g_jmp_page
      assign jmp_pc = {pc_q[AW-1:12], ir_q[11:0]};
    end else begin : g_jmp_flat
      assign jmp_pc = ir_q[AW-1:0];
    end
  endgenerate

  assign accept = (state_q == S_ISSUE) && issue_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= RESET_PC;
      addr_q    <= '0;
      ir_q      <= '0;
      discard_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      ir_q      <= ir_d;
      discard_q <= discard_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (redirect)      state_d = S_FETCH;
        else if (imem_ack) state_d = S_ISSUE;
        else               state_d = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) state_d = (redirect || discard_q) ? S_FETCH : S_ISSUE;
      end
      S_ISSUE: begin
        if (redirect)         state_d = S_FETCH;
        else if (issue_ready) state_d = (ir_q[15:12] == OP_HALT) ? S_HALT : S_FETCH;
      end
      default: state_d = S_HALT;
    endcase
  end

  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    ir_d      = ir_q;
    discard_d = discard_q;
    if (state_q == S_FETCH) addr_d = pc_q;
    if ((state_q == S_FETCH || state_q == S_WAIT) && imem_ack && !redirect && !discard_q)
      ir_d = imem_rdata;
    // A redirect during an outstanding fetch must still wait out the ack
    if (state_q == S_WAIT) begin
      if (imem_ack)      discard_d = 1'b0;
      else if (redirect) discard_d = 1'b1;
    end
    if (redirect && state_q != S_HALT) begin
      pc_d = redirect_pc;
    end else if (accept) begin
      if (ir_q[15:12] == OP_JMP)       pc_d = jmp_pc;
      else if (ir_q[15:12] != OP_HALT) pc_d = pc_q + AW'(1);
    end
  end

  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = '0;
    issue_valid = 1'b0;
    halted      = 1'b0;
    ir_vis      = '0;
    issue_pc    = '0;
    if (rst_n) begin
      ir_vis   = ir_q;
      issue_pc = addr_q;
      case (state_q)
        S_FETCH: begin
          imem_req  = 1'b1;
          imem_addr = pc_q;
        end
        S_WAIT: begin
          imem_req  = 1'b1;
          imem_addr = addr_q;
        end
        S_ISSUE: issue_valid = 1'b1;
        default: halted      = 1'b1;
      endcase
    end
  end

  assign opcode = ir_vis[15:12];
  assign rs     = ir_vis[11:8];
  assign rt     = ir_vis[7:4];
  assign func   = ir_vis[3:0];
  assign imm    = ir_vis[3:0];

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_issue.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_instr_fetch_issue : directed vectors and corner sequences             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_instr_fetch_issue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        issue_valid;
  logic        issue_ready = 1'b0;
  logic [3:0]  opcode, func, rs, rt, imm;
  logic [15:0] issue_pc;
  logic        redirect = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        halted;

  always #5 clk = ~clk;

  instr_fetch_issue #(.AW(16), .RESET_PC(16'h0000)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .issue_valid (issue_valid),
    .issue_ready (issue_ready),
    .opcode      (opcode),
    .func        (func),
    .rs          (rs),
    .rt          (rt),
    .imm         (imm),
    .issue_pc    (issue_pc),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halted      (halted)
  );

  // Instruction memory model: acks after wait_cycles of held request
  logic [15:0] mem [logic [15:0]];
  int          wait_cycles = 0;
  int          mcnt = 0;
  logic        auto_ack = 1'b0;
  logic [15:0] auto_rdata = 16'h0000;
  logic        force_ack = 1'b0;

  assign imem_ack   = auto_ack | force_ack;
  assign imem_rdata = force_ack ? 16'h3111 : auto_rdata;

  always @(posedge clk) begin
    #1;
    auto_ack = 1'b0;
    if (imem_req) begin
      if (mcnt >= wait_cycles) begin
        auto_ack   = 1'b1;
        auto_rdata = mem.exists(imem_addr) ? mem[imem_addr] : 16'h0000;
        mcnt       = 0;
      end else begin
        mcnt++;
      end
    end else begin
      mcnt = 0;
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_valid(input int max);
    for (int i = 0; i < max; i++) begin
      if (issue_valid === 1'b1) return;
      tick();
    end
  endtask

  task automatic goto_pc(input logic [15:0] a);
    redirect_pc = a;
    redirect    = 1'b1;
    tick();
    redirect    = 1'b0;
  endtask

  task automatic accept_one();
    issue_ready = 1'b1;
    tick();
    issue_ready = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr;
    logic [15:0] instr;
    logic [3:0]  op;
    logic [3:0]  rs;
    logic [3:0]  rt;
    logic [3:0]  fn;
    logic [15:0] nxt;
  } vec_t;

  vec_t vt [6];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    logic       bad;
    logic [3:0] seen_op;

    vt[0] = '{16'h0000, 16'h0123, 4'h0, 4'h1, 4'h2, 4'h3, 16'h0001};
    vt[1] = '{16'h1005, 16'h6ABC, 4'h6, 4'hA, 4'hB, 4'hC, 16'h1ABC};
    vt[2] = '{16'hFFFF, 16'h6000, 4'h6, 4'h0, 4'h0, 4'h0, 16'hF000};
    vt[3] = '{16'hFFFF, 16'h1234, 4'h1, 4'h2, 4'h3, 4'h4, 16'h0000};
    vt[4] = '{16'h0200, 16'h8F5A, 4'h8, 4'hF, 4'h5, 4'hA, 16'h0201};
    vt[5] = '{16'h0300, 16'hB07E, 4'hB, 4'h0, 4'h7, 4'hE, 16'h0301};

    mem[16'h0000] = 16'h0123;
    tick();
    tick();
    chk("reset imem_req", imem_req, 0);
    chk("reset issue_valid", issue_valid, 0);
    chk("reset halted", halted, 0);
    chk("reset imem_addr", imem_addr, 0);
    chk("reset opcode", opcode, 0);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      mem[vt[i].addr] = vt[i].instr;
      if (i > 0) goto_pc(vt[i].addr);
      wait_valid(20);
      chk($sformatf("v%0d valid", i), issue_valid, 1);
      chk($sformatf("v%0d issue_pc", i), issue_pc, vt[i].addr);
      chk($sformatf("v%0d opcode", i), opcode, vt[i].op);
      chk($sformatf("v%0d rs", i), rs, vt[i].rs);
      chk($sformatf("v%0d rt", i), rt, vt[i].rt);
      chk($sformatf("v%0d func", i), func, vt[i].fn);
      chk($sformatf("v%0d imm", i), imm, vt[i].fn);
      accept_one();
      chk($sformatf("v%0d next req", i), imem_req, 1);
      chk($sformatf("v%0d next addr", i), imem_addr, vt[i].nxt);
    end

    // Back-pressure: fields held, no fetch, PC moves only on accept
    mem[16'h0500] = 16'h2345;
    goto_pc(16'h0500);
    wait_valid(20);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("hold cycle %0d", i),
          {issue_valid, imem_req, opcode, rs, rt, func, issue_pc},
          {1'b1, 1'b0, 16'h2345, 16'h0500});
      tick();
    end
    accept_one();
    chk("hold next addr", imem_addr, 16'h0501);

    // Redirect while an imem access is outstanding
    mem[16'h0030] = 16'h3111;
    mem[16'h0040] = 16'h5432;
    wait_cycles = 3;
    goto_pc(16'h0030);
    chk("disc fetch addr", imem_addr, 16'h0030);
    tick();
    redirect_pc = 16'h0040;
    redirect    = 1'b1;
    tick();
    redirect    = 1'b0;
    chk("disc req held", {imem_req, imem_addr}, {1'b1, 16'h0030});
    bad = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (issue_valid) bad = 1'b1;
      if (imem_req && imem_addr == 16'h0040) break;
      tick();
    end
    chk("disc refetch addr", imem_addr, 16'h0040);
    chk("disc data issued", bad, 0);
    wait_valid(20);
    chk("disc issue_pc", issue_pc, 16'h0040);
    chk("disc opcode", opcode, 4'h5);
    wait_cycles = 0;

    // Halt, stay quiet, ignore redirect, then reset
    mem[16'h0600] = 16'hF000;
    goto_pc(16'h0600);
    wait_valid(20);
    chk("halt opcode", opcode, 4'hF);
    accept_one();
    chk("halted set", halted, 1);
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 5) redirect = 1'b1;
      if (i == 6) redirect = 1'b0;
      if (imem_req || issue_valid || !halted) bad = 1'b1;
      tick();
    end
    chk("halt quiet", bad, 0);
    rst_n = 1'b0;
    #1;
    chk("halt reset clears", halted, 0);
    tick();
    rst_n = 1'b1;
    #1;
    chk("halt refetch addr", {imem_req, imem_addr}, {1'b1, 16'h0000});
    wait_valid(20);
    chk("halt refetch pc", issue_pc, 16'h0000);
    chk("halt refetch rt", rt, 4'h2);

    // Reset in the middle of an outstanding fetch, late ack during reset
    mem[16'h0700] = 16'h7777;
    wait_cycles = 3;
    goto_pc(16'h0700);
    tick();
    rst_n = 1'b0;
    #1;
    chk("midwait reset req/valid", {imem_req, issue_valid}, 2'b00);
    tick();
    force_ack = 1'b1;
    chk("midwait reset req", imem_req, 0);
    tick();
    force_ack   = 1'b0;
    wait_cycles = 0;
    rst_n       = 1'b1;
    #1;
    chk("midwait restart addr", {imem_req, imem_addr}, {1'b1, 16'h0000});
    wait_valid(20);
    seen_op = opcode;
    chk("midwait restart pc", issue_pc, 16'h0000);
    chk("midwait stale ack", {seen_op, rs}, {4'h0, 4'h1});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
